// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM encoding and GF(2^8) helpers.
package aes_pkg;
   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_256 = 4'd14;

   typedef enum logic [1:0] {IDLE, INIT, ROUND} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction
endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round; last skips MixColumns.
module aes_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] key,
   input  logic         last,
   output logic [127:0] next_state
);
   logic [127:0] sub, shf, mix;

   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
              mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   genvar i;
   for (i = 0; i < 16; i++) begin : g_byte
      assign sub[127-8*i -: 8] = SBOX[state[127-8*i -: 8]];
      // byte 4c+r takes row r from column (c+r) mod 4
      assign shf[127-8*i -: 8] = sub[127-8*((i+4*(i%4))%16) -: 8];
   end
   for (i = 0; i < 4; i++) begin : g_col
      assign mix[127-32*i -: 32] = mix_col(shf[127-32*i -: 32]);
   end

   assign next_state = (last ? shf : mix) ^ key;
endmodule

// File: rtl/aes_encipher.sv
// aes_encipher: iterative AES-128/256 encryption, one round per clock.
module aes_encipher
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         next,
   input  logic         keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);
   state_t st, st_n;
   logic [3:0] nr, nr_n, round_n;
   logic [127:0] blk_n, rnd_out;
   logic ready_n;

   aes_round u_round (
      .state(new_block),
      .key(round_key),
      .last(round == nr),
      .next_state(rnd_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         nr        <= NR_128;
         round     <= '0;
         new_block <= '0;
         ready     <= 1'b0;
      end else begin
         st        <= st_n;
         nr        <= nr_n;
         round     <= round_n;
         new_block <= blk_n;
         ready     <= ready_n;
      end
   end

   always_comb begin
      st_n    = st;
      nr_n    = nr;
      round_n = round;
      blk_n   = new_block;
      ready_n = ready;
      case (st)
         IDLE: if (next) begin
            blk_n   = block;
            nr_n    = keylen ? NR_256 : NR_128;
            round_n = 4'd0;
            ready_n = 1'b0;
            st_n    = INIT;
         end
         INIT: begin
            blk_n   = new_block ^ round_key;
            round_n = 4'd1;
            st_n    = ROUND;
         end
         ROUND: begin
            blk_n = rnd_out;
            if (round == nr) begin
               ready_n = 1'b1;
               st_n    = IDLE;
            end else begin
               round_n = round + 4'd1;
            end
         end
         default: st_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_aes_encipher.sv
// tb_aes_encipher: FIPS-197 vectors plus random vectors against a byte-level AES model.
module tb_aes_encipher;
   logic clk = 1'b0, rst_n = 1'b0, next = 1'b0, keylen = 1'b0;
   logic [3:0] round;
   logic [127:0] block = '0, new_block, round_key;
   logic ready;
   logic [127:0] rk [16];
   logic [7:0] sb [256];
   int passes = 0, total = 0;

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT3   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] INIT1 = 128'h00102030405060708090a0b0c0d0e0f0;

   aes_encipher dut (
      .clk(clk), .rst_n(rst_n), .next(next), .keylen(keylen), .round(round),
      .round_key(round_key), .block(block), .new_block(new_block), .ready(ready)
   );

   assign round_key = rk[round];
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   function automatic void expand(input logic [255:0] key, input bit kl);
      int nk = kl ? 8 : 4;
      int nr = kl ? 14 : 10;
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0] rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input bit kl);
      logic [7:0] s [4][4];
      logic [7:0] t [4][4];
      logic [127:0] out;
      int nr = kl ? 14 : 10;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk[0][127-8*(4*c+r) -: 8];
      for (int n = 1; n <= nr; n++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sb[s[r][(c+r)%4]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[r][c] = (n == nr) ? t[r][c] :
                         gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[r][c] ^= rk[n][127-8*(4*c+r) -: 8];
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            out[127-8*(4*c+r) -: 8] = s[r][c];
      return out;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Starts one encryption at the current negedge and follows it to completion.
   // poke: round at which a spurious start is pulsed; abort: round at which reset is asserted.
   task automatic run(input bit kl, input logic [127:0] pt, input logic [127:0] exp,
                      input int poke, input int abort, input bit chk_init);
      int nr = kl ? 14 : 10;
      next = 1'b1;
      keylen = kl;
      block = pt;
      @(negedge clk);
      next = 1'b0;
      keylen = ~kl;
      chk("ready_drop", 128'(ready), 128'(0));
      chk("round0", 128'(round), 128'(0));
      for (int k = 1; k <= nr; k++) begin
         @(negedge clk);
         chk("round_seq", 128'(round), 128'(k));
         if (k == abort) begin
            rst_n = 1'b0;
            #1;
            chk("rst_ready", 128'(ready), 128'(0));
            chk("rst_round", 128'(round), 128'(0));
            chk("rst_block", new_block, 128'(0));
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         chk("busy", 128'(ready), 128'(0));
         if (chk_init && k == 1) chk("init_state", new_block, INIT1);
         next = (k == poke);
         if (k == poke) block = ~pt;
      end
      @(negedge clk);
      chk("ready", 128'(ready), 128'(1));
      chk("round_hold", 128'(round), 128'(nr));
      chk("result", new_block, exp);
   endtask

   initial begin
      logic [255:0] key;
      logic [127:0] pt;
      bit kl;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      for (int r = 0; r < 16; r++) rk[r] = '0;
      #1;
      chk("reset_ready", 128'(ready), 128'(0));
      chk("reset_round", 128'(round), 128'(0));
      chk("reset_block", new_block, 128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      expand(KEY1, 1'b0);
      run(1'b0, PT, CT1, 0, 0, 1'b1);
      repeat (3) @(negedge clk);
      chk("ready_hold", 128'(ready), 128'(1));
      chk("result_hold", new_block, CT1);

      expand(KEY3, 1'b1);
      run(1'b1, PT, CT3, 0, 0, 1'b0);

      expand(KEY1, 1'b0);
      run(1'b0, PT, CT1, 5, 0, 1'b0);

      run(1'b0, PT, CT1, 0, 4, 1'b0);
      run(1'b0, PT, CT1, 0, 0, 1'b1);

      for (int n = 0; n < 200; n++) begin
         kl = n[0];
         key = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
         pt = {$urandom(), $urandom(), $urandom(), $urandom()};
         expand(key, kl);
         run(kl, pt, encrypt(pt, kl), 0, 0, 1'b0);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
